spi_reg_decoder: RTL and testbench

Command decoder downstream of `spi_slave`: consumes received SPI bytes (already in the system clock domain) and turns each chip-select frame into register-bank accesses for the DDS control registers. The first byte of a frame selects read or write and a start address. Following bytes are written with address auto-increment, or are answered with prefetched read data handed back to `spi_slave` for shifting out on MISO.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_reg_decoder.sv | 114 +++++++++++
 tb/tb_spi_reg_decoder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI register decoder: command byte layout, frame FSM
// state encoding and the minimum byte spacing the decoder is built for.
package spi_pkg;

  localparam int CMD_RD_BIT   = 7;
  localparam int MIN_BYTE_GAP = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD      = 3'd5;

endpackage

// File: rtl/spi_reg_decoder.sv
// Turns SPI frames (command byte + data/dummy bytes) into register-bank writes
// and prefetched reads with address auto-increment. ADDR_W must not exceed 7.
module spi_reg_decoder
  import spi_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_cs_n,
  input  logic [7:0]        in_rx_byte,
  input  logic              in_rx_valid,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_valid,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wr_data,
  output logic              o_reg_wr_en,
  output logic              o_reg_rd_en,
  input  logic [7:0]        in_reg_rd_data,
  output logic              o_overrun,
  output logic [7:0]        o_dbg_byte
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [2:0] state;
  logic       cs_n_q;
  logic       cs_fall;
  logic       cs_rise;

  assign cs_fall = cs_n_q & ~in_cs_n;
  assign cs_rise = ~cs_n_q & in_cs_n;

  // NOTE: every register here uses <= so all state updates see the values from
  // before the edge; mixing in = would make the result depend on statement order.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state         <= ST_IDLE;
      cs_n_q        <= 1'b1;
      o_tx_byte     <= '0;
      o_tx_valid    <= 1'b0;
      o_reg_addr    <= '0;
      o_reg_wr_data <= '0;
      o_reg_wr_en   <= 1'b0;
      o_reg_rd_en   <= 1'b0;
      o_overrun     <= 1'b0;
      o_dbg_byte    <= '0;
    end else begin
      cs_n_q      <= in_cs_n;
      o_tx_valid  <= 1'b0;
      o_reg_wr_en <= 1'b0;
      o_reg_rd_en <= 1'b0;

      // The write issued last cycle used the current address; advance it now.
      if (o_reg_wr_en) o_reg_addr <= o_reg_addr + ADDR_ONE;

      if (in_cs_n) begin
        state <= ST_IDLE;
        // A data byte landing on the deselect edge still completes its write.
        if (cs_rise && in_rx_valid && state == ST_WR) begin
          o_reg_wr_en   <= 1'b1;
          o_reg_wr_data <= in_rx_byte;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state     <= ST_CMD;
              o_overrun <= 1'b0;
            end
          end
          ST_CMD: begin
            if (in_rx_valid) begin
              o_dbg_byte <= in_rx_byte;
              o_reg_addr <= in_rx_byte[ADDR_W-1:0];
              if (in_rx_byte[CMD_RD_BIT]) begin
                o_reg_rd_en <= 1'b1;
                state       <= ST_RD_REQ;
              end else begin
                state <= ST_WR;
              end
            end
          end
          ST_WR: begin
            if (in_rx_valid) begin
              o_reg_wr_en   <= 1'b1;
              o_reg_wr_data <= in_rx_byte;
            end
          end
          ST_RD_REQ: begin
            // The strobe is raised on entry; this cycle the bank sees it.
            if (in_rx_valid) o_overrun <= 1'b1;
            state <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            if (in_rx_valid) o_overrun <= 1'b1;
            o_tx_byte  <= in_reg_rd_data;
            o_tx_valid <= 1'b1;
            o_reg_addr <= o_reg_addr + ADDR_ONE;
            state      <= ST_RD;
          end
          ST_RD: begin
            if (in_rx_valid) begin
              o_reg_rd_en <= 1'b1;
              state       <= ST_RD_REQ;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench for spi_reg_decoder: frame vectors from a table, expected
// bank accesses queued by a behavioural model and matched as the DUT emits them.
module tb_spi_reg_decoder;
  import spi_pkg::*;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX} ev_e;

  typedef struct {
    ev_e        kind;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] b;
    logic [7:0]      dbg;
    logic [6:0]      addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic [6:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data = '0;
  logic       overrun;
  logic [7:0] dbg_byte;

  int n_vec = 0;
  int n_err = 0;

  ev_t        exp_q[$];
  logic [7:0] bank    [128];
  logic [7:0] exp_mem [128];
  logic [7:0] exp_tx_last = '0;
  bit         abort_mode = 1'b0;
  int         rd_cnt = 0;
  int         tx_cnt = 0;
  vec_t       vecs [8];

  always #5 clk = ~clk;

  spi_reg_decoder #(.ADDR_W(7)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_cs_n       (cs_n),
    .in_rx_byte    (rx_byte),
    .in_rx_valid   (rx_valid),
    .o_tx_byte     (tx_byte),
    .o_tx_valid    (tx_valid),
    .o_reg_addr    (reg_addr),
    .o_reg_wr_data (reg_wr_data),
    .o_reg_wr_en   (reg_wr_en),
    .o_reg_rd_en   (reg_rd_en),
    .in_reg_rd_data(reg_rd_data),
    .o_overrun     (overrun),
    .o_dbg_byte    (dbg_byte)
  );

  // Register bank: read data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (reg_wr_en) bank[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= bank[reg_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_event(input ev_e kind, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_%s: got addr %0h data %0h, nothing expected", kind.name(), addr, data);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(kind), 32'(e.kind));
      if (kind != EV_TX) check("ev_addr", 32'(addr), 32'(e.addr));
      if (kind != EV_RD) check("ev_data", 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en || reg_rd_en) check("wr_rd_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
      if (reg_wr_en) check_event(EV_WR, reg_addr, reg_wr_data);
      if (abort_mode) begin
        if (reg_rd_en) rd_cnt++;
        if (tx_valid)  tx_cnt++;
      end else begin
        if (reg_rd_en) check_event(EV_RD, reg_addr, 8'h00);
        if (tx_valid)  check_event(EV_TX, 7'h00, tx_byte);
      end
    end
  end

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] dbg, input logic [6:0] addr);
    vec_t v;
    v.n    = 3'(n);
    v.b[0] = b0;
    v.b[1] = b1;
    v.b[2] = b2;
    v.b[3] = b3;
    v.dbg  = dbg;
    v.addr = addr;
    return v;
  endfunction

  task automatic push(input ev_e kind, input logic [6:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Behavioural model: one fetch per command/dummy byte, one write per data byte.
  task automatic push_frame(input vec_t v);
    logic [6:0] a;
    a = v.b[0][6:0];
    if (v.b[0][7]) begin
      for (int i = 0; i < int'(v.n); i++) begin
        push(EV_RD, a, 8'h00);
        push(EV_TX, 7'h00, exp_mem[a]);
        exp_tx_last = exp_mem[a];
        a = a + 7'd1;
      end
    end else begin
      for (int i = 1; i < int'(v.n); i++) begin
        push(EV_WR, a, v.b[i]);
        exp_mem[a] = v.b[i];
        a = a + 7'd1;
      end
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    push_frame(v);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(v.n); i++) begin
      strobe(v.b[i]);
      repeat (MIN_BYTE_GAP - 1) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_dbg"}, 32'(dbg_byte), 32'(v.dbg));
    check({name, "_addr"}, 32'(reg_addr), 32'(v.addr));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      bank[i]    = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    bank[16'h10] = 8'hAB; exp_mem[16'h10] = 8'hAB;
    bank[16'h11] = 8'hCD; exp_mem[16'h11] = 8'hCD;

    vecs[0] = mk(4, 8'h05, 8'h11, 8'h22, 8'h33, 8'h05, 7'h08);  // write burst
    vecs[1] = mk(3, 8'h90, 8'h00, 8'h00, 8'h00, 8'h90, 7'h13);  // read burst
    vecs[2] = mk(3, 8'h7F, 8'h01, 8'h02, 8'h00, 8'h7F, 7'h01);  // address wrap
    vecs[3] = mk(1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 7'h20);  // write cmd only
    vecs[4] = mk(1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 7'h26);  // read cmd only
    vecs[5] = mk(3, 8'h30, 8'hC3, 8'h3C, 8'h00, 8'h30, 7'h32);  // write then
    vecs[6] = mk(3, 8'hB0, 8'h00, 8'h00, 8'h00, 8'hB0, 7'h33);  // read back
    vecs[7] = mk(2, 8'h45, 8'h77, 8'h00, 8'h00, 8'h45, 7'h46);  // after abort

    repeat (3) @(negedge clk);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_dbg", 32'(dbg_byte), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_strobes", {29'd0, reg_wr_en, reg_rd_en, tx_valid}, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort: deselect one cycle after a read command.
    abort_mode = 1'b1;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    rx_byte  = 8'hC0;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    cs_n     = 1'b1;
    repeat (6) @(negedge clk);
    abort_mode = 1'b0;
    check("abort_rd_at_most_one", 32'(rd_cnt <= 1), 32'd1);
    check("abort_no_tx", 32'(tx_cnt), 32'd0);
    check("abort_tx_held", 32'(tx_byte), 32'(exp_tx_last));
    check("abort_addr_held", 32'(reg_addr), 32'h40);
    run_vec(vecs[7], "post_abort");

    // Overrun: second byte one cycle after a read command.
    push(EV_RD, 7'h10, 8'h00);
    push(EV_TX, 7'h00, exp_mem[16'h10]);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    rx_byte  = 8'h90;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_byte  = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("overrun_one_fetch", 32'(exp_q.size()), 32'd0);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);

    // Last data byte coincides with deselect: the write still completes.
    push(EV_WR, 7'h60, 8'h12);
    push(EV_WR, 7'h61, 8'h34);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    strobe(8'h60);
    repeat (MIN_BYTE_GAP - 1) @(negedge clk);
    strobe(8'h12);
    repeat (MIN_BYTE_GAP - 1) @(negedge clk);
    rx_byte  = 8'h34;
    rx_valid = 1'b1;
    cs_n     = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("edge_write_done", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a write frame.
    push(EV_WR, 7'h50, 8'h99);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    strobe(8'h50);
    repeat (MIN_BYTE_GAP - 1) @(negedge clk);
    strobe(8'h99);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("mid_rst_addr", 32'(reg_addr), 32'd0);
    check("mid_rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("mid_rst_dbg", 32'(dbg_byte), 32'd0);
    check("mid_rst_tx", {23'd0, tx_valid, tx_byte}, 32'd0);
    check("mid_rst_rd_ovr", {30'd0, reg_rd_en, overrun}, 32'd0);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    strobe(8'hEE);
    repeat (MIN_BYTE_GAP) @(negedge clk);
    check("deselected_byte_dbg", 32'(dbg_byte), 32'd0);
    check("deselected_byte_addr", 32'(reg_addr), 32'd0);
    run_vec(mk(2, 8'h0A, 8'h5C, 8'h00, 8'h00, 8'h0A, 7'h0B), "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
